// File: rtl/instr_exec_sequencer_pkg.sv
// Shared types and constants for the instruction execution stage.
// Instruction/operand/result types are common to the instruction register and its sequencer.
package instr_exec_sequencer_pkg;

  localparam int         DIV_ITERS = 32;
  localparam logic [4:0] LFSR_TAPS = 5'b10100;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef enum logic [1:0] {
    INC  = 2'd0,
    DEC  = 2'd1,
    RAND = 2'd2
  } order_t;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;
  typedef logic        [4:0]  address_t;

  typedef struct packed {
    opcode_t  opcode;
    operand_t op_a;
    operand_t op_b;
    result_t  rezultat;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    EXEC   = 3'd2,
    DIVIDE = 3'd3,
    WRITE  = 3'd4,
    FINISH = 3'd5
  } exec_state_t;

  // Fibonacci LFSR x^5+x^3+1: shift left, feedback from the tapped bits.
  function automatic address_t lfsrNext(input address_t value);
    return {value[3:0], ^(value & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/instr_exec_sequencer_divider.sv
// Iterative signed restoring divider: one quotient bit per cycle on magnitudes,
// signs applied to the outputs (quotient truncates toward zero, remainder follows dividend).
module instr_divider
  import instr_exec_sequencer_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     i_start,
  input  operand_t i_a,
  input  operand_t i_b,
  output result_t  o_quotient,
  output result_t  o_remainder,
  output logic     o_done
);

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_divisor;
  logic        r_negQ;
  logic        r_negR;
  logic [5:0]  r_iter;

  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [63:0] w_quoMag;
  logic [63:0] w_remMag;

  assign w_absA = i_a[31] ? (32'd0 - i_a) : i_a;
  assign w_absB = i_b[31] ? (32'd0 - i_b) : i_b;

  function automatic logic [63:0] divStep(input logic [31:0] rem, input logic [31:0] quo,
                                          input logic [31:0] divisor);
    logic [32:0] shifted;
    logic [32:0] diff;
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[32])
      return {diff[31:0], quo[30:0], 1'b1};
    return {shifted[31:0], quo[30:0], 1'b0};
  endfunction

  // The start cycle already performs the first iteration, so the result is
  // ready after DIV_ITERS clock edges counting the start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_iter    <= '0;
    end else if (i_start) begin
      {r_rem, r_quo} <= divStep(32'd0, w_absA, w_absB);
      r_divisor      <= w_absB;
      r_negQ         <= i_a[31] ^ i_b[31];
      r_negR         <= i_a[31];
      r_iter         <= 6'd1;
    end else if (r_iter != 6'd0 && r_iter < 6'(DIV_ITERS)) begin
      {r_rem, r_quo} <= divStep(r_rem, r_quo, r_divisor);
      r_iter         <= r_iter + 6'd1;
    end
  end

  assign w_quoMag    = {32'd0, r_quo};
  assign w_remMag    = {32'd0, r_rem};
  assign o_quotient  = r_negQ ? (64'd0 - w_quoMag) : w_quoMag;
  assign o_remainder = r_negR ? (64'd0 - w_remMag) : w_remMag;
  assign o_done      = (r_iter == 6'(DIV_ITERS));

endmodule

// File: rtl/instr_exec_sequencer.sv
// Walks a range of instruction entries, executes each opcode and writes the
// signed result back to the same entry.
module instr_exec_sequencer
  import instr_exec_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  order_t       i_order,
  input  address_t     i_first_addr,
  input  logic [5:0]   i_count,
  output address_t     o_rd_addr,
  input  instruction_t i_rd_data,
  output logic         o_wr_en,
  output address_t     o_wr_addr,
  output result_t      o_wr_result,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_div0,
  output logic         o_illegal_op
);

  exec_state_t r_state;
  order_t      r_order;
  address_t    r_addr;
  logic [5:0]  r_remaining;
  opcode_t     r_opcode;
  operand_t    r_opA;
  operand_t    r_opB;
  logic        r_wrEn;
  address_t    r_wrAddr;
  result_t     r_wrResult;
  logic        r_busy;
  logic        r_done;
  logic        r_div0;
  logic        r_illegal;

  result_t     w_a;
  result_t     w_b;
  result_t     w_execResult;
  logic        w_execIllegal;
  logic        w_isDiv;
  logic        w_divByZero;
  logic        w_divStart;
  result_t     w_divQuo;
  result_t     w_divRem;
  logic        w_divDone;
  address_t    w_startAddr;
  logic [5:0]  w_startCount;
  address_t    w_nextAddr;
  logic        w_unused;

  assign w_unused = ^i_rd_data.rezultat;

  assign w_a         = {{32{r_opA[31]}}, r_opA};
  assign w_b         = {{32{r_opB[31]}}, r_opB};
  assign w_isDiv     = (r_opcode == DIV) || (r_opcode == MOD);
  assign w_divByZero = w_isDiv && (r_opB == 32'sd0);
  assign w_divStart  = (r_state == EXEC) && w_isDiv && !w_divByZero;

  // A zero RAND seed would lock the LFSR; its period of 31 caps the pass length.
  assign w_startAddr  = (i_order == RAND && i_first_addr == 5'd0) ? 5'd1 : i_first_addr;
  assign w_startCount = (i_order == RAND && i_count > 6'd31) ? 6'd31 : i_count;

  always_comb begin
    w_execResult  = '0;
    w_execIllegal = 1'b0;
    case (r_opcode)
      ZERO:     w_execResult = '0;
      PASSA:    w_execResult = w_a;
      PASSB:    w_execResult = w_b;
      ADD:      w_execResult = w_a + w_b;
      SUB:      w_execResult = w_a - w_b;
      MULT:     w_execResult = w_a * w_b;
      DIV, MOD: w_execResult = '0;
      default:  w_execIllegal = 1'b1;
    endcase
  end

  always_comb begin
    w_nextAddr = r_addr + 5'd1;
    case (r_order)
      DEC:     w_nextAddr = r_addr - 5'd1;
      RAND:    w_nextAddr = lfsrNext(r_addr);
      default: w_nextAddr = r_addr + 5'd1;
    endcase
  end

  instr_divider u_divider (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_divStart),
    .i_a        (r_opA),
    .i_b        (r_opB),
    .o_quotient (w_divQuo),
    .o_remainder(w_divRem),
    .o_done     (w_divDone)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_order     <= INC;
      r_addr      <= '0;
      r_remaining <= '0;
      r_opcode    <= ZERO;
      r_opA       <= '0;
      r_opB       <= '0;
      r_wrEn      <= 1'b0;
      r_wrAddr    <= '0;
      r_wrResult  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div0      <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_wrEn <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_order     <= i_order;
            r_addr      <= w_startAddr;
            r_remaining <= w_startCount;
            r_div0      <= 1'b0;
            r_illegal   <= 1'b0;
            r_busy      <= 1'b1;
            if (i_count == 6'd0) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= READ;
            end
          end
        end
        READ: begin
          r_opcode <= i_rd_data.opcode;
          r_opA    <= i_rd_data.op_a;
          r_opB    <= i_rd_data.op_b;
          r_state  <= EXEC;
        end
        EXEC: begin
          if (w_execIllegal) r_illegal <= 1'b1;
          if (w_divByZero)   r_div0    <= 1'b1;
          if (w_divStart) begin
            r_state <= DIVIDE;
          end else begin
            r_wrEn     <= 1'b1;
            r_wrAddr   <= r_addr;
            r_wrResult <= w_execResult;
            r_state    <= WRITE;
          end
        end
        DIVIDE: begin
          if (w_divDone) begin
            r_wrEn     <= 1'b1;
            r_wrAddr   <= r_addr;
            r_wrResult <= (r_opcode == DIV) ? w_divQuo : w_divRem;
            r_state    <= WRITE;
          end
        end
        WRITE: begin
          r_addr      <= w_nextAddr;
          r_remaining <= r_remaining - 6'd1;
          if (r_remaining == 6'd1) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
          end else begin
            r_state <= READ;
          end
        end
        FINISH: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_rd_addr    = r_addr;
  assign o_wr_en      = r_wrEn;
  assign o_wr_addr    = r_wrAddr;
  assign o_wr_result  = r_wrResult;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_div0       = r_div0;
  assign o_illegal_op = r_illegal;

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// Self-checking bench for instr_exec_sequencer: directed vector table, hand-written
// corner sequences and randomized passes checked against a behavioural model.
module tb_instr_exec_sequencer;
  import instr_exec_sequencer_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_start = 1'b0;
  order_t       i_order = INC;
  address_t     i_first_addr = '0;
  logic [5:0]   i_count = '0;
  address_t     o_rd_addr;
  instruction_t i_rd_data;
  logic         o_wr_en;
  address_t     o_wr_addr;
  result_t      o_wr_result;
  logic         o_busy;
  logic         o_done;
  logic         o_div0;
  logic         o_illegal_op;

  instruction_t mem [32];

  int nChecks = 0;
  int nPass   = 0;

  address_t gotAddr[$];
  result_t  gotRes[$];
  int       gotCyc[$];
  int       doneCyc;
  logic     gotDiv0;
  logic     gotIll;

  address_t expAddr[$];
  result_t  expRes[$];
  int       expCyc[$];
  int       expDone;
  logic     expDiv0;
  logic     expIll;

  typedef struct {
    logic [3:0] op;
    operand_t   a;
    operand_t   b;
    result_t    res;
    logic       div0;
    logic       ill;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  always_comb i_rd_data = mem[o_rd_addr];

  instr_exec_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_order     (i_order),
    .i_first_addr(i_first_addr),
    .i_count     (i_count),
    .o_rd_addr   (o_rd_addr),
    .i_rd_data   (i_rd_data),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_result (o_wr_result),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_div0      (o_div0),
    .o_illegal_op(o_illegal_op)
  );

  function automatic instruction_t mkInstr(input logic [3:0] op, input operand_t a, input operand_t b);
    instruction_t x;
    x.opcode   = opcode_t'(op);
    x.op_a     = a;
    x.op_b     = b;
    x.rezultat = '0;
    return x;
  endfunction

  function automatic operand_t randOperand();
    operand_t corner [4];
    corner[0] = 32'sd0;
    corner[1] = -32'sd1;
    corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF;
    case ($urandom_range(0, 3))
      0:       return operand_t'($urandom_range(0, 20)) - 32'sd10;
      1:       return corner[$urandom_range(0, 3)];
      default: return operand_t'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    else
      nPass++;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd_addr"},   64'(o_rd_addr),    64'd0);
    checkOutput({tag, "_wr_en"},     64'(o_wr_en),      64'd0);
    checkOutput({tag, "_wr_addr"},   64'(o_wr_addr),    64'd0);
    checkOutput({tag, "_wr_result"}, o_wr_result,       64'd0);
    checkOutput({tag, "_busy"},      64'(o_busy),       64'd0);
    checkOutput({tag, "_done"},      64'(o_done),       64'd0);
    checkOutput({tag, "_div0"},      64'(o_div0),       64'd0);
    checkOutput({tag, "_illegal"},   64'(o_illegal_op), 64'd0);
  endtask

  // Starts a pass (start is high during cycle 0) and records every write and the done cycle.
  task automatic applyStimulus(input order_t ord, input address_t first, input logic [5:0] cnt);
    int cyc;
    gotAddr.delete();
    gotRes.delete();
    gotCyc.delete();
    doneCyc = -1;
    gotDiv0 = 1'b0;
    gotIll  = 1'b0;
    @(negedge clk);
    i_start      = 1'b1;
    i_order      = ord;
    i_first_addr = first;
    i_count      = cnt;
    @(negedge clk);
    i_start = 1'b0;
    cyc     = 1;
    checkOutput("busy_rise", 64'(o_busy), 64'd1);
    while (cyc < 3000 && doneCyc < 0) begin
      if (o_wr_en) begin
        gotAddr.push_back(o_wr_addr);
        gotRes.push_back(o_wr_result);
        gotCyc.push_back(cyc);
      end
      if (o_done) begin
        doneCyc = cyc;
        gotDiv0 = o_div0;
        gotIll  = o_illegal_op;
        checkOutput("busy_at_done", 64'(o_busy), 64'd1);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput("done_seen", 64'(doneCyc >= 0), 64'd1);
    @(negedge clk);
    checkOutput("done_pulse_width", 64'(o_done), 64'd0);
    checkOutput("busy_fall", 64'(o_busy), 64'd0);
  endtask

  // Reference: address sequence, results and write cycles derived from the pass rules.
  task automatic buildExpected(input order_t ord, input address_t first, input logic [5:0] cnt);
    int       n;
    int       t;
    int       op;
    logic [4:0] lfsr;
    address_t a;
    longint   x;
    longint   y;
    longint   r;
    expAddr.delete();
    expRes.delete();
    expCyc.delete();
    expDiv0 = 1'b0;
    expIll  = 1'b0;
    n    = int'(cnt);
    lfsr = first;
    if (ord == RAND) begin
      if (lfsr == 5'd0) lfsr = 5'd1;
      if (n > 31) n = 31;
    end
    t = 0;
    for (int i = 0; i < n; i++) begin
      case (ord)
        INC:     a = address_t'((int'(first) + i) % 32);
        DEC:     a = address_t'((int'(first) - i + 64) % 32);
        default: begin
          a    = lfsr;
          lfsr = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
        end
      endcase
      op = int'(mem[a].opcode);
      x  = longint'(mem[a].op_a);
      y  = longint'(mem[a].op_b);
      r  = 0;
      t += 3;
      case (op)
        0: r = 0;
        1: r = x;
        2: r = y;
        3: r = x + y;
        4: r = x - y;
        5: r = x * y;
        6, 7: begin
          if (y == 0) expDiv0 = 1'b1;
          else begin
            r = (op == 6) ? x / y : x % y;
            t += 32;
          end
        end
        default: expIll = 1'b1;
      endcase
      expAddr.push_back(a);
      expRes.push_back(r);
      expCyc.push_back(t);
    end
    expDone = t + 1;
  endtask

  task automatic comparePass(input string tag);
    int n;
    checkOutput({tag, "_nwrites"}, 64'(gotAddr.size()), 64'(expAddr.size()));
    n = (gotAddr.size() < expAddr.size()) ? gotAddr.size() : expAddr.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), 64'(gotAddr[i]), 64'(expAddr[i]));
      checkOutput($sformatf("%s_res%0d", tag, i), gotRes[i], expRes[i]);
      checkOutput($sformatf("%s_cyc%0d", tag, i), 64'(gotCyc[i]), 64'(expCyc[i]));
    end
    checkOutput({tag, "_done_cyc"}, 64'(doneCyc), 64'(expDone));
    checkOutput({tag, "_div0"},     64'(gotDiv0), 64'(expDiv0));
    checkOutput({tag, "_illegal"},  64'(gotIll),  64'(expIll));
  endtask

  initial begin
    address_t   a;
    order_t     ord;
    logic [5:0] cnt;
    logic [31:0] seen;
    int         dup;
    int         zeroHits;
    int         nWr;

    for (int i = 0; i < 32; i++) mem[i] = mkInstr(4'd0, 32'sd0, 32'sd0);

    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;

    // INC pass wrapping 31 -> 0
    mem[30] = mkInstr(4'd3, 32'sd5, 32'sd7);
    mem[31] = mkInstr(4'd4, 32'sd3, 32'sd10);
    mem[0]  = mkInstr(4'd5, -32'sd4, 32'sd6);
    applyStimulus(INC, 5'd30, 6'd3);
    checkOutput("inc_nwrites", 64'(gotAddr.size()), 64'd3);
    if (gotAddr.size() == 3) begin
      checkOutput("inc_addr0", 64'(gotAddr[0]), 64'd30);
      checkOutput("inc_addr1", 64'(gotAddr[1]), 64'd31);
      checkOutput("inc_addr2", 64'(gotAddr[2]), 64'd0);
      checkOutput("inc_res0", gotRes[0], 64'sd12);
      checkOutput("inc_res1", gotRes[1], -64'sd7);
      checkOutput("inc_res2", gotRes[2], -64'sd24);
      checkOutput("inc_cyc2", 64'(gotCyc[2]), 64'd9);
    end
    checkOutput("inc_done_cyc", 64'(doneCyc), 64'd10);

    // DEC pass wrapping 0 -> 31 with divides
    mem[0]  = mkInstr(4'd6, -32'sd7, 32'sd2);
    mem[31] = mkInstr(4'd7, -32'sd7, 32'sd2);
    applyStimulus(DEC, 5'd0, 6'd2);
    checkOutput("dec_nwrites", 64'(gotAddr.size()), 64'd2);
    if (gotAddr.size() == 2) begin
      checkOutput("dec_addr0", 64'(gotAddr[0]), 64'd0);
      checkOutput("dec_addr1", 64'(gotAddr[1]), 64'd31);
      checkOutput("dec_res0", gotRes[0], -64'sd3);
      checkOutput("dec_res1", gotRes[1], -64'sd1);
      checkOutput("dec_cyc0", 64'(gotCyc[0]), 64'd35);
      checkOutput("dec_cyc1", 64'(gotCyc[1]), 64'd70);
    end
    checkOutput("dec_done_cyc", 64'(doneCyc), 64'd71);

    // Empty pass
    applyStimulus(INC, 5'd3, 6'd0);
    checkOutput("empty_nwrites", 64'(gotAddr.size()), 64'd0);
    checkOutput("empty_done_cyc", 64'(doneCyc), 64'd1);

    // Single-entry vector table
    vecs.push_back('{4'd3, 32'sd5, 32'sd7, 64'sd12, 1'b0, 1'b0, 3});
    vecs.push_back('{4'd4, 32'sd3, 32'sd10, -64'sd7, 1'b0, 1'b0, 3});
    vecs.push_back('{4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0, 1'b0, 3});
    vecs.push_back('{4'd5, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 3});
    vecs.push_back('{4'd6, 32'h8000_0000, -32'sd1, 64'sd2147483648, 1'b0, 1'b0, 35});
    vecs.push_back('{4'd7, 32'h8000_0000, -32'sd1, 64'sd0, 1'b0, 1'b0, 35});
    vecs.push_back('{4'd6, 32'sd100, 32'sd0, 64'sd0, 1'b1, 1'b0, 3});
    vecs.push_back('{4'd3, 32'sd1, 32'sd2, 64'sd3, 1'b0, 1'b0, 3});
    vecs.push_back('{4'd7, -32'sd7, 32'sd0, 64'sd0, 1'b1, 1'b0, 3});
    vecs.push_back('{4'd7, 32'sd7, -32'sd2, 64'sd1, 1'b0, 1'b0, 35});
    vecs.push_back('{4'd6, 32'sd7, -32'sd2, -64'sd3, 1'b0, 1'b0, 35});
    vecs.push_back('{4'd1, -32'sd1, 32'sd9, -64'sd1, 1'b0, 1'b0, 3});
    vecs.push_back('{4'd2, 32'sd9, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0, 3});
    vecs.push_back('{4'd0, 32'sd9, 32'sd9, 64'sd0, 1'b0, 1'b0, 3});
    vecs.push_back('{4'd9, 32'sd9, 32'sd9, 64'sd0, 1'b0, 1'b1, 3});
    vecs.push_back('{4'd15, 32'sd1, 32'sd1, 64'sd0, 1'b0, 1'b1, 3});
    vecs.push_back('{4'd4, 32'h8000_0000, 32'sd1, 64'hFFFF_FFFF_7FFF_FFFF, 1'b0, 1'b0, 3});
    for (int i = 0; i < vecs.size(); i++) begin
      a      = address_t'((i * 7) % 32);
      mem[a] = mkInstr(vecs[i].op, vecs[i].a, vecs[i].b);
      applyStimulus(INC, a, 6'd1);
      checkOutput($sformatf("vec%0d_nwrites", i), 64'(gotAddr.size()), 64'd1);
      if (gotAddr.size() == 1) begin
        checkOutput($sformatf("vec%0d_addr", i), 64'(gotAddr[0]), 64'(a));
        checkOutput($sformatf("vec%0d_res", i), gotRes[0], vecs[i].res);
        checkOutput($sformatf("vec%0d_lat", i), 64'(gotCyc[0]), 64'(vecs[i].lat));
      end
      checkOutput($sformatf("vec%0d_div0", i), 64'(gotDiv0), 64'(vecs[i].div0));
      checkOutput($sformatf("vec%0d_illegal", i), 64'(gotIll), 64'(vecs[i].ill));
    end

    // RAND seed 0 with count 32: 31 distinct nonzero addresses starting at 1
    for (int i = 0; i < 32; i++) mem[i] = mkInstr(4'd3, operand_t'(i), operand_t'(3 * i));
    applyStimulus(RAND, 5'd0, 6'd32);
    checkOutput("rand_nwrites", 64'(gotAddr.size()), 64'd31);
    if (gotAddr.size() > 0) checkOutput("rand_first", 64'(gotAddr[0]), 64'd1);
    seen = '0;
    dup = 0;
    zeroHits = 0;
    foreach (gotAddr[i]) begin
      if (gotAddr[i] == 5'd0) zeroHits++;
      if (seen[gotAddr[i]]) dup++;
      seen[gotAddr[i]] = 1'b1;
    end
    checkOutput("rand_dups", 64'(dup), 64'd0);
    checkOutput("rand_zero_addr", 64'(zeroHits), 64'd0);
    buildExpected(RAND, 5'd0, 6'd32);
    comparePass("rand32");

    // Reset while the second entry is dividing
    mem[4] = mkInstr(4'd3, 32'sd1, 32'sd1);
    mem[5] = mkInstr(4'd6, 32'sd1000, 32'sd3);
    mem[6] = mkInstr(4'd3, 32'sd2, 32'sd2);
    @(negedge clk);
    i_start      = 1'b1;
    i_order      = INC;
    i_first_addr = 5'd4;
    i_count      = 6'd3;
    @(negedge clk);
    i_start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("mid_busy", 64'(o_busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    checkAllZero("midreset");
    reset = 1'b0;
    nWr = 0;
    repeat (80) begin
      @(negedge clk);
      if (o_wr_en || o_done) nWr++;
    end
    checkOutput("midreset_no_activity", 64'(nWr), 64'd0);
    buildExpected(INC, 5'd4, 6'd3);
    applyStimulus(INC, 5'd4, 6'd3);
    comparePass("after_reset");

    // Randomized passes against the reference model
    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < 32; i++) begin
        logic [3:0] op;
        op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
        mem[i] = mkInstr(op, randOperand(), randOperand());
      end
      ord = order_t'($urandom_range(0, 2));
      a   = address_t'($urandom_range(0, 31));
      cnt = ($urandom_range(0, 9) == 0) ? 6'd32 : 6'($urandom_range(0, 6));
      buildExpected(ord, a, cnt);
      applyStimulus(ord, a, cnt);
      comparePass($sformatf("rnd%0d", p));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
